// File: rtl/conv1_act_scheduler.sv
// conv1_act_scheduler: round-robin share of one conv1 requantize/ReLU stage,
// packing int8 activations 4 per word. Optional macro: CONV1_ACT_SAT_CNT_EN.
module conv1_act_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 16
) (
    input  logic                    nice_clk,
    input  logic                    nice_rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        cfg_count,
    input  logic [NUM_LANES-1:0]    acc_valid,
    input  logic [NUM_LANES*20-1:0] acc_data,
    output logic [NUM_LANES-1:0]    acc_ready,
    output logic                    wb_valid,
    output logic [31:0]             wb_data,
    output logic                    wb_last,
    input  logic                    wb_ready,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             sat_count
);

    localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_rem;
    logic [PW-1:0]    r_ptr;
    logic [1:0]       r_byte_cnt;
    logic [23:0]      r_pack;
    logic             r_wb_valid;
    logic [31:0]      r_wb_data;
    logic             r_wb_last;

    logic [19:0]        w_lane [NUM_LANES];
    logic               w_gnt_any;
    logic [PW-1:0]      w_gnt_idx;
    logic [PW-1:0]      w_ptr_nxt;
    logic [PW:0]        w_sum;
    logic [19:0]        w_din;
    logic signed [19:0] w_sh;
    logic signed [19:0] w_a;
    logic [7:0]         w_byte;
    logic               w_stall;
    logic               w_accept;
    logic               w_last_acc;
    logic               w_wb_hs;
    logic               w_flush_ld;
    logic               w_start_ok;

    // Split the flat accumulator bus into per-lane words.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_lane[i] = acc_data[20*i +: 20];
        end
    end

    // Round-robin search upward from the pointer; lowest offset wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NUM_LANES)) begin
                w_sum = w_sum - (PW+1)'(NUM_LANES);
            end
            if (acc_valid[w_sum[PW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_sum[PW-1:0];
            end
        end
    end

    assign w_din     = w_lane[w_gnt_idx];
    assign w_ptr_nxt = (w_gnt_idx == PW'(NUM_LANES - 1)) ? '0
                     : w_gnt_idx + 1'b1;

    // Requantize then clamp to the ReLU int8 range 0..127.
    assign w_sh   = ($signed(w_din) >>> 2) - 20'sd128;
    assign w_a    = w_sh >>> 5;
    assign w_byte = (w_a > 20'sd127) ? 8'd127
                  : (w_a < 20'sd0)   ? 8'd0
                  : w_a[7:0];

    assign w_stall    = (r_byte_cnt == 2'd3) && r_wb_valid && !wb_ready;
    assign w_accept   = (r_state == S_RUN) && w_gnt_any
                     && (r_rem != '0) && !w_stall;
    assign w_last_acc = w_accept && (r_rem == CNT_W'(1));
    assign w_wb_hs    = r_wb_valid && wb_ready;
    assign w_flush_ld = (r_state == S_FLUSH) && (!r_wb_valid || wb_ready);
    assign w_start_ok = (r_state == S_IDLE) && start;

    // One-hot accept toward the granted lane.
    always_comb begin
        acc_ready = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            acc_ready[i] = w_accept && (w_gnt_idx == PW'(i));
        end
    end

    // FSM state register.
    always_ff @(posedge nice_clk) begin
        if (!nice_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (cfg_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_acc) begin
                    w_state_nxt = (r_byte_cnt == 2'd3) ? S_DRAIN : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_flush_ld) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_wb_hs) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pass bookkeeping: remaining count, RR pointer and byte packing.
    always_ff @(posedge nice_clk) begin
        if (!nice_rst_n) begin
            r_rem      <= '0;
            r_ptr      <= '0;
            r_byte_cnt <= 2'd0;
            r_pack     <= 24'd0;
        end else if (w_start_ok) begin
            r_rem      <= cfg_count;
            r_ptr      <= '0;
            r_byte_cnt <= 2'd0;
            r_pack     <= 24'd0;
        end else if (w_accept) begin
            r_rem      <= r_rem - CNT_W'(1);
            r_ptr      <= w_ptr_nxt;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
                r_pack <= 24'd0;
            end else begin
                r_pack[8*r_byte_cnt +: 8] <= w_byte;
            end
        end else if (w_flush_ld) begin
            r_byte_cnt <= 2'd0;
            r_pack     <= 24'd0;
        end
    end

    // Writeback register: full word, flushed partial word, or drained.
    always_ff @(posedge nice_clk) begin
        if (!nice_rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= 32'd0;
            r_wb_last  <= 1'b0;
        end else if (w_accept && (r_byte_cnt == 2'd3)) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= {w_byte, r_pack};
            r_wb_last  <= w_last_acc;
        end else if (w_flush_ld) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= {8'd0, r_pack};
            r_wb_last  <= 1'b1;
        end else if (w_wb_hs) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_data  = r_wb_data;
    assign wb_last  = r_wb_last;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

`ifdef CONV1_ACT_SAT_CNT_EN
    logic [15:0] r_sat;

    // Count accepted activations that clipped at the top of the range.
    always_ff @(posedge nice_clk) begin
        if (!nice_rst_n) begin
            r_sat <= 16'd0;
        end else if (w_start_ok) begin
            r_sat <= 16'd0;
        end else if (w_accept && (w_a > 20'sd127) && (r_sat != 16'hFFFF)) begin
            r_sat <= r_sat + 16'd1;
        end
    end

    assign sat_count = r_sat;
`else
    assign sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_conv1_act_scheduler.sv
// tb_conv1_act_scheduler: directed bench for the conv1 activation scheduler.
// Expected words and grants are hand-computed from the activation formula.
module tb_conv1_act_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] cfg_count;
    logic [3:0]  acc_valid;
    logic [79:0] acc_data;
    logic [3:0]  acc_ready;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        wb_last;
    logic        wb_ready;
    logic        busy;
    logic        done;
    logic [15:0] sat_count;

    int checks;
    int errors;

`ifdef CONV1_ACT_SAT_CNT_EN
    localparam int SAT_ON = 1;
`else
    localparam int SAT_ON = 0;
`endif

    logic [31:0] q_data [$];
    logic        q_last [$];
    logic [3:0]  q_gnt  [$];
    int          n_acc;
    int          done_c;
    int          hs_c;
    bit          timed_out;

    conv1_act_scheduler #(
        .NUM_LANES(4),
        .CNT_W    (16)
    ) dut (
        .nice_clk  (clk),
        .nice_rst_n(rst_n),
        .start     (start),
        .cfg_count (cfg_count),
        .acc_valid (acc_valid),
        .acc_data  (acc_data),
        .acc_ready (acc_ready),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_last   (wb_last),
        .wb_ready  (wb_ready),
        .busy      (busy),
        .done      (done),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [79:0] pk(input int d3, input int d2,
                                       input int d1, input int d0);
        return {20'(d3), 20'(d2), 20'(d1), 20'(d0)};
    endfunction

    // Pulse start and observe one pass until done or a cycle budget expires.
    task automatic run_pass(input logic [15:0] cnt);
        q_data.delete();
        q_last.delete();
        q_gnt.delete();
        n_acc = 0;
        done_c = -1;
        hs_c = -1;
        timed_out = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cfg_count = cnt;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (acc_ready != 4'd0) begin
                q_gnt.push_back(acc_ready);
                n_acc++;
            end
            if (wb_valid && wb_ready) begin
                q_data.push_back(wb_data);
                q_last.push_back(wb_last);
                hs_c = c;
            end
            if (done) begin
                done_c = c;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        cfg_count = 16'd0;
        acc_valid = 4'd0;
        acc_data = 80'd0;
        wb_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({acc_ready, wb_valid, wb_last, busy, done} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0",
                     {acc_ready, wb_valid, wb_last, busy, done});
        end
        checks++;
        if (wb_data !== 32'd0 || sat_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0", wb_data, sat_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_four_lanes();
        acc_valid = 4'hF;
        acc_data = pk(0, 20992, 1024, 4608);
        wb_ready = 1'b1;
        run_pass(16'd4);
        checks++;
        if (timed_out || n_acc != 4) begin
            errors++;
            $display("FAIL four_accepts got %0d to=%0d want 4", n_acc, timed_out);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_gnt.size() <= i || q_gnt[i] !== 4'(1 << i)) begin
                errors++;
                $display("FAIL four_grant%0d got %b want %b",
                         i, (q_gnt.size() > i) ? q_gnt[i] : 4'hx, 4'(1 << i));
            end
        end
        checks++;
        if (q_data.size() != 1 || q_data[0] !== 32'h007F0420
            || q_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL four_word got n=%0d %h want 1 007f0420 last",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'hx);
        end
        checks++;
        if (done_c != hs_c + 1) begin
            errors++;
            $display("FAIL four_done_lat got %0d want %0d", done_c, hs_c + 1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL four_done_pulse got d=%b b=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_single_lane();
        int bad;
        acc_valid = 4'b0010;
        acc_data = pk(0, 0, 4608, 0);
        wb_ready = 1'b1;
        run_pass(16'd6);
        bad = 0;
        foreach (q_gnt[i]) if (q_gnt[i] !== 4'b0010) bad++;
        checks++;
        if (timed_out || n_acc != 6 || bad != 0) begin
            errors++;
            $display("FAIL single_grants got n=%0d bad=%0d want 6 0", n_acc, bad);
        end
        checks++;
        if (q_data.size() != 2) begin
            errors++;
            $display("FAIL single_nwords got %0d want 2", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 32'h20202020 || q_last[0] !== 1'b0) begin
                errors++;
                $display("FAIL single_w0 got %h/%b want 20202020/0",
                         q_data[0], q_last[0]);
            end
            checks++;
            if (q_data[1] !== 32'h00002020 || q_last[1] !== 1'b1) begin
                errors++;
                $display("FAIL single_w1 got %h/%b want 00002020/1",
                         q_data[1], q_last[1]);
            end
        end
    endtask

    task automatic test_stall();
        int seq;
        int held;
        int stall_acc;
        bit seen;
        bit got_done;
        logic [31:0] w [$];
        logic        l [$];
        seq = 0;
        held = 0;
        stall_acc = 0;
        seen = 1'b0;
        got_done = 1'b0;
        acc_valid = 4'hF;
        wb_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cfg_count = 16'd8;
        for (int c = 0; c < 80 && !got_done; c++) begin
            @(negedge clk);
            start = 1'b0;
            acc_data = {4{20'(512 + 128 * (seq + 1))}};
            if (wb_valid) seen = 1'b1;
            if (seen && held < 6) begin
                wb_ready = 1'b0;
                held++;
            end else begin
                wb_ready = 1'b1;
            end
            #1;
            if (!wb_ready) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_data !== 32'h04030201) begin
                    errors++;
                    $display("FAIL stall_hold got %b/%h want 1/04030201",
                             wb_valid, wb_data);
                end
            end
            if (!wb_ready && held == 6) begin
                checks++;
                if (acc_ready !== 4'd0) begin
                    errors++;
                    $display("FAIL stall_ready got %b want 0000", acc_ready);
                end
            end
            if (acc_ready != 4'd0) begin
                seq++;
                if (!wb_ready) stall_acc++;
            end
            if (wb_valid && wb_ready) begin
                w.push_back(wb_data);
                l.push_back(wb_last);
            end
            if (done) got_done = 1'b1;
        end
        wb_ready = 1'b1;
        checks++;
        if (!got_done || stall_acc != 3 || seq != 8) begin
            errors++;
            $display("FAIL stall_accepts got d=%0d s=%0d n=%0d want 1 3 8",
                     got_done, stall_acc, seq);
        end
        checks++;
        if (w.size() != 2 || w[0] !== 32'h04030201 || l[0] !== 1'b0
            || w[1] !== 32'h08070605 || l[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_words got n=%0d %h %h want 04030201 08070605",
                     w.size(), (w.size() > 0) ? w[0] : 32'hx,
                     (w.size() > 1) ? w[1] : 32'hx);
        end
    endtask

    task automatic test_zero_count();
        bit any_wb;
        any_wb = 1'b0;
        acc_valid = 4'd0;
        wb_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cfg_count = 16'd0;
        @(negedge clk);
        #1;
        if (wb_valid) any_wb = 1'b1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done got d=%b b=%b want 1 1", done, busy);
        end
        start = 1'b1;
        cfg_count = 16'd4;
        acc_valid = 4'hF;
        @(negedge clk);
        start = 1'b0;
        #1;
        if (wb_valid) any_wb = 1'b1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || acc_ready !== 4'd0) begin
            errors++;
            $display("FAIL zero_ignore got d=%b b=%b r=%b want 0 0 0",
                     done, busy, acc_ready);
        end
        @(negedge clk);
        #1;
        if (wb_valid) any_wb = 1'b1;
        checks++;
        if (busy !== 1'b0 || any_wb) begin
            errors++;
            $display("FAIL zero_idle got b=%b wb=%b want 0 0", busy, any_wb);
        end
        acc_valid = 4'd0;
    endtask

    task automatic test_reset_mid_pass();
        acc_valid = 4'hF;
        acc_data = pk(4608, 4608, 4608, 4608);
        wb_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cfg_count = 16'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || acc_ready !== 4'd0 || wb_valid !== 1'b0
            || wb_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid got b=%b r=%b v=%b d=%h want 0",
                     busy, acc_ready, wb_valid, wb_data);
        end
        rst_n = 1'b1;
        acc_data = pk(1024, 896, 768, 640);
        run_pass(16'd4);
        checks++;
        if (timed_out || q_data.size() != 1 || q_data[0] !== 32'h04030201
            || q_last[0] !== 1'b1 || q_gnt[0] !== 4'b0001) begin
            errors++;
            $display("FAIL rst_new_pass got n=%0d %h want 1 04030201",
                     q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'hx);
        end
    endtask

    task automatic test_sat();
        acc_valid = 4'hF;
        acc_data = pk(20992, 20992, 20992, 20992);
        wb_ready = 1'b1;
        run_pass(16'd5);
        checks++;
        if (sat_count !== 16'(5 * SAT_ON)) begin
            errors++;
            $display("FAIL sat_five got %0d want %0d", sat_count, 5 * SAT_ON);
        end
        checks++;
        if (timed_out || q_data.size() != 2 || q_data[0] !== 32'h7F7F7F7F
            || q_data[1] !== 32'h0000007F || q_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_words got n=%0d want 7f7f7f7f 0000007f",
                     q_data.size());
        end
        acc_data = pk(700, 0, -100000, 500000);
        run_pass(16'd4);
        checks++;
        if (sat_count !== 16'(SAT_ON)) begin
            errors++;
            $display("FAIL sat_clear got %0d want %0d", sat_count, SAT_ON);
        end
        checks++;
        if (q_data.size() != 1 || q_data[0] !== 32'h0100007F) begin
            errors++;
            $display("FAIL clamp_word got %h want 0100007f",
                     (q_data.size() > 0) ? q_data[0] : 32'hx);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_four_lanes();
        test_single_lane();
        test_stall();
        test_zero_count();
        test_reset_mid_pass();
        test_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv1_act_scheduler.md
# conv1_act_scheduler

Round-robin scheduler that shares a single conv-layer-1 requantize/ReLU activation stage among `NUM_LANES` PE accumulator lanes. It packs the resulting int8 activations four per 32-bit word and streams them to the NICE writeback path with a valid/ready handshake. It sits between the PE array accumulators and the conv1 output buffer writer. One pass is started per output tile by the NICE control logic.

## Interface
- `NUM_LANES`, 4: number of accumulator requesters, 2..8.
- `CNT_W`, 16: width of the activation count.
- `nice_clk`  in  1  clock.
- `nice_rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  pulse, begins a pass; ignored while `busy`.
- `cfg_count`  in  CNT_W  number of activations in the pass; sampled on accepted `start`.
- `acc_valid`  in  NUM_LANES  per-lane accumulator result valid.
- `acc_data`  in  NUM_LANES*20  per-lane signed 20-bit accumulator; lane i at [20i+19:20i].
- `acc_ready`  out  NUM_LANES  one-hot grant/accept.
- `wb_valid`  out  1  packed word valid.
- `wb_data`  out  32  packed activations, first byte in [7:0].
- `wb_last`  out  1  final word of the pass; qualified by `wb_valid`.
- `wb_ready`  in  1  writeback accepts word.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle pulse at pass end.
- `sat_count`  out  16  saturation counter (see Configuration).

## Operation
- Activation function, signed arithmetic throughout: `a = ((din >>> 2) - 128) >>> 5` at 20 bits, then `dout = a > 127 ? 127 : (a < 0 ? 0 : a)`. `dout` is unsigned 0..127 in 8 bits.
- FSM states:
  - IDLE: on `start`, if `cfg_count == 0` go to DONE; otherwise load `remaining = cfg_count`, reset the RR pointer to lane 0, and go to RUN.
  - RUN: accept activations. When the last activation is accepted, go to FLUSH if a partial word is pending, else to DRAIN.
  - FLUSH: move the partial word, zero-padded in the upper bytes, into the wb register as soon as it is free. Then go to DRAIN.
  - DRAIN: wait for the last word's `wb_valid && wb_ready`, then go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- `busy` is high in every state except IDLE.
- Arbitration: in RUN, grant the first lane with `acc_valid` set, searching upward from the RR pointer with wrap-around. On an accept, the pointer becomes granted lane + 1 (mod NUM_LANES). At most one accept per cycle.
- `acc_ready[i]` is high only when all of the following hold: state is RUN, lane i is granted, `remaining > 0`, and there is no stall. A stall is `byte_cnt == 3 && wb_valid && !wb_ready`.
  - `acc_ready` never depends combinationally on `wb_ready` except through this stall term.
- Packing: each accepted byte is written into byte lane `byte_cnt` of the pack register, and `byte_cnt` is incremented.
  - On the 4th byte, the full word moves to the wb register (`wb_valid` = 1), `byte_cnt` = 0, and the pack register is cleared.
  - `wb_last` is set on the word containing activation number `cfg_count`.
- `wb_data` and `wb_last` are held stable while `wb_valid && !wb_ready`.

## Timing
- Reset values:
  - `acc_ready` = 0, `wb_valid` = 0, `wb_data` = 0, `wb_last` = 0.
  - `busy` = 0, `done` = 0, `sat_count` = 0.
  - FSM in IDLE, RR pointer 0, `byte_cnt` 0.
- `start` at cycle t: RUN at t+1; first accept possible at t+1.
- 4th byte accepted at cycle t: `wb_valid` = 1 at t+1.
- Throughput is one activation per cycle while `wb_ready` stays high.
- A new full word may load into the wb register in the same cycle the old word handshakes.
- `done` fires the cycle after the last `wb_valid && wb_ready`. For `cfg_count == 0`, `done` fires at t+1 and no word is emitted.
- Reset asserted mid-pass aborts immediately: all state returns to reset values at the next edge, and partial data is discarded.

## Configuration
- `CONV1_ACT_SAT_CNT_EN` defined:
  - `sat_count` increments on every accepted activation whose `a > 127`.
  - It saturates at 0xFFFF and clears on an accepted `start`.
- Not defined: `sat_count` is constant 0 and the counter logic is absent.

## Test plan
- All 4 lanes valid with `acc_data` = {0, 20992, 1024, 4608} (lanes 3..0), `cfg_count` = 4, `wb_ready` = 1 → grants in order 0,1,2,3. One word with `wb_data` = 0x007F0420 and `wb_last` = 1, then a `done` pulse.
- `cfg_count` = 6, lane 1 only valid, `din` = 4608 → words 0x20202020 (`wb_last` = 0) then 0x00002020 (`wb_last` = 1).
- `wb_ready` held 0 after the first full word, `cfg_count` = 8 → exactly 3 further accepts, then `acc_ready` = 0. `wb_data` stays stable. Releasing `wb_ready` resumes with no loss or duplication.
- `cfg_count` = 0 → `done` at t+1, `wb_valid` never asserted. A second `start` while `busy` is ignored.
- Reset asserted after 2 accepts, then a new pass with `cfg_count` = 4 → first word contains only the new data.
- With `CONV1_ACT_SAT_CNT_EN`, 5 activations of `din` = 20992 → `sat_count` = 5. Without the macro → `sat_count` = 0.
